// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that pairs bytes (low byte first) into 16-bit words and presents
// each word with a port_write level held for a fixed number of cycles.
module uart_word_rx #(
    parameter int unsigned div     = 434,
    parameter int unsigned hold    = 64,
    parameter int unsigned timeout = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [15:0] port_in,
    output logic        port_write,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    localparam logic [15:0] L_HALF_M1 = 16'(div / 2 - 1);
    localparam logic [15:0] L_DIV_M1  = 16'(div - 1);
    localparam logic [15:0] L_HOLD_M1 = 16'(hold - 1);
    localparam logic [15:0] L_TO_M1   = 16'(timeout - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [1:0]  r_sync;
    logic        w_rxs;
    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic [7:0]  r_low;
    logic        r_pending;
    logic [15:0] r_gap;
    logic [15:0] r_word;
    logic        r_word_valid;
    logic [15:0] r_port_in;
    logic        r_port_write;
    logic [15:0] r_hold_cnt;
    logic        r_frame_err;

    // Two-stage synchroniser; idles high so a reset never fakes a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    assign w_rxs = r_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 16'd0;
            r_bit        <= 3'd0;
            r_shift      <= 8'd0;
            r_low        <= 8'd0;
            r_pending    <= 1'b0;
            r_gap        <= 16'd0;
            r_word       <= 16'd0;
            r_word_valid <= 1'b0;
            r_port_in    <= 16'd0;
            r_port_write <= 1'b0;
            r_hold_cnt   <= 16'd0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err  <= 1'b0;
            r_word_valid <= 1'b0;

            // A completed word restarts the hold window even if port_write is already high.
            if (r_word_valid) begin
                r_port_in    <= r_word;
                r_port_write <= 1'b1;
                r_hold_cnt   <= L_HOLD_M1;
            end else if (r_port_write) begin
                if (r_hold_cnt == 16'd0) begin
                    r_port_write <= 1'b0;
                end else begin
                    r_hold_cnt <= r_hold_cnt - 16'd1;
                end
            end

            if (r_pending && (r_state == S_IDLE)) begin
                if (r_gap == L_TO_M1) begin
                    r_pending <= 1'b0;
                    r_gap     <= 16'd0;
                end else begin
                    r_gap <= sat_inc(r_gap);
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= S_START;
                        r_cnt   <= 16'd0;
                    end
                end
                S_START: begin
                    if (r_cnt == L_HALF_M1) begin
                        r_cnt   <= 16'd0;
                        r_bit   <= 3'd0;
                        r_state <= w_rxs ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                S_DATA: begin
                    if (r_cnt == L_DIV_M1) begin
                        r_cnt   <= 16'd0;
                        r_shift <= {w_rxs, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                S_STOP: begin
                    if (r_cnt == L_DIV_M1) begin
                        r_cnt   <= 16'd0;
                        r_state <= S_IDLE;
                        r_gap   <= 16'd0;
                        if (w_rxs) begin
                            if (r_pending) begin
                                r_word       <= {r_shift, r_low};
                                r_word_valid <= 1'b1;
                                r_pending    <= 1'b0;
                            end else begin
                                r_low     <= r_shift;
                                r_pending <= 1'b1;
                            end
                        end else begin
                            // Bad stop bit poisons the whole pair, not just this byte.
                            r_frame_err <= 1'b1;
                            r_pending   <= 1'b0;
                        end
                    end else begin
                        r_cnt <= sat_inc(r_cnt);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign port_in    = r_port_in;
    assign port_write = r_port_write;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != S_IDLE) || r_pending;

endmodule

// File: tb/tb_uart_word_rx.sv
// Bench for uart_word_rx: table of byte pairs plus hand-written corner sequences,
// with a scoreboard queue of expected words checked whenever a word is presented.
module tb_uart_word_rx;

    logic        clk;
    logic        reset;
    logic        rx;
    logic [15:0] port_in;
    logic        port_write;
    logic        frame_err;
    logic        busy;
    logic [15:0] pin_l;
    logic        pw_l;
    logic        fe_l;
    logic        busy_l;

    int n_checks = 0;
    int n_errors = 0;
    int fe_count = 0;
    int rise_l   = 0;
    int fall_l   = 0;
    int high_l   = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] word;
    } vec_t;
    vec_t vecs[4];

    uart_word_rx #(.div(4), .hold(8), .timeout(100)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .port_in(port_in), .port_write(port_write),
        .frame_err(frame_err), .busy(busy)
    );

    // A short hold cannot overlap two 80-cycle word transfers, so the reload case
    // is observed on a second instance with a long hold window.
    uart_word_rx #(.div(4), .hold(100), .timeout(100)) dut_long (
        .clk(clk), .reset(reset), .rx(rx),
        .port_in(pin_l), .port_write(pw_l),
        .frame_err(fe_l), .busy(busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (4) tick();
        end
        rx = stop;
        repeat (4) tick();
        rx = 1'b1;
    endtask

    // Called right after the high byte's stop bit has been driven.
    task automatic check_word(input logic [15:0] exp);
        int n;
        tick();
        check("pw_before_word", 32'(port_write), 32'd0);
        tick();
        check("word_latency", 32'(port_in), 32'(exp));
        check("pw_rise", 32'(port_write), 32'd1);
        n = 0;
        while (port_write && n < 50) begin
            n++;
            tick();
        end
        check("pw_width", 32'(n), 32'd8);
    endtask

    // Scoreboard and pulse monitors, sampled on the falling edge.
    initial begin
        logic        prev_pw  = 1'b0;
        logic [15:0] prev_pin = 16'd0;
        logic        prev_pwl = 1'b0;
        logic [15:0] exp_word;
        forever begin
            @(negedge clk);
            if (!reset && port_write && (!prev_pw || port_in != prev_pin)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected: got %0h expected none", port_in);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("sb_word", 32'(port_in), 32'(exp_word));
                end
            end
            if (frame_err) fe_count++;
            if (pw_l && !prev_pwl) rise_l++;
            if (!pw_l && prev_pwl) fall_l++;
            if (pw_l) high_l++;
            prev_pw  = port_write;
            prev_pin = port_in;
            prev_pwl = pw_l;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe_before;
        int n;

        vecs[0] = '{8'h34, 8'h12, 16'h1234};
        vecs[1] = '{8'h00, 8'hFF, 16'hFF00};
        vecs[2] = '{8'hFF, 8'h00, 16'h00FF};
        vecs[3] = '{8'hA5, 8'h5A, 16'h5AA5};

        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) tick();
        check("rst_port_in", 32'(port_in), 32'd0);
        check("rst_pw", 32'(port_write), 32'd0);
        check("rst_fe", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (5) tick();

        // One-clock glitch: START entered after sync latency, then rejected.
        rx = 1'b0;
        tick();
        rx = 1'b1;
        tick();
        tick();
        check("glitch_busy_start", 32'(busy), 32'd1);
        tick();
        tick();
        check("glitch_busy_idle", 32'(busy), 32'd0);
        repeat (5) tick();
        check("glitch_no_fe", 32'(fe_count), 32'd0);

        // Bad stop bit drops the pending low byte too.
        fe_before = fe_count;
        send_byte(8'h99, 1'b1);
        send_byte(8'h55, 1'b0);
        tick();
        check("fe_pulse", 32'(frame_err), 32'd1);
        check("fe_pending_clear", 32'(busy), 32'd0);
        check("fe_port_in", 32'(port_in), 32'h0000);
        tick();
        check("fe_one_cycle", 32'(frame_err), 32'd0);
        check("fe_count", 32'(fe_count - fe_before), 32'd1);
        exp_q.push_back(16'hABCD);
        send_byte(8'hCD, 1'b1);
        send_byte(8'hAB, 1'b1);
        check_word(16'hABCD);

        // Back-to-back pairs from the table.
        fe_before = fe_count;
        for (int v = 0; v < 4; v++) begin
            exp_q.push_back(vecs[v].word);
            send_byte(vecs[v].lo, 1'b1);
            send_byte(vecs[v].hi, 1'b1);
            check_word(vecs[v].word);
            repeat (3) tick();
        end
        check("table_no_fe", 32'(fe_count - fe_before), 32'd0);

        // Gap timeout: pending held for exactly timeout idle cycles.
        exp_q.push_back(16'h3456);
        send_byte(8'h78, 1'b1);
        repeat (100) tick();
        check("gap_before_timeout", 32'(busy), 32'd1);
        tick();
        check("gap_timeout", 32'(busy), 32'd0);
        repeat (49) tick();
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        check_word(16'h3456);

        // Reload while port_write is high (long-hold instance).
        n = 0;
        while (pw_l && n < 500) begin
            n++;
            tick();
        end
        check("long_idle", 32'(pw_l), 32'd0);
        rise_l = 0;
        fall_l = 0;
        high_l = 0;
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        send_byte(8'h11, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h22, 1'b1);
        n = 0;
        while (n < 300 && !(fall_l > 0 && !pw_l)) begin
            n++;
            tick();
        end
        check("reload_rises", 32'(rise_l), 32'd1);
        check("reload_falls", 32'(fall_l), 32'd1);
        check("reload_high_cycles", 32'(high_l), 32'd180);
        check("reload_port_in", 32'(pin_l), 32'h2222);
        check("reload_main_port_in", 32'(port_in), 32'h2222);

        // Reset during bit 5 of the high byte.
        send_byte(8'hEF, 1'b1);
        rx = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            rx = (i == 0 || i > 4) ? 1'b0 : 1'b1;
            repeat (4) tick();
        end
        rx = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("midrst_port_in", 32'(port_in), 32'd0);
        check("midrst_pw", 32'(port_write), 32'd0);
        check("midrst_fe", 32'(frame_err), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (20) tick();
        check("midrst_still_idle", 32'(busy), 32'd0);
        exp_q.push_back(16'hBEEF);
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        check_word(16'hBEEF);

        repeat (20) tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
